// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC, IF/ID register, redirect/stall/flush, STOP drain and fetch counter
module if_stage #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = 16'hFFFF,
  parameter int                    DRAIN_CYCLES = 3,
  parameter int                    CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] instruction_mem_addr_o,
  input  logic [DATA_WIDTH-1:0] instruction_mem_rD_i,
  input  logic                  stall_IF_ID_i,
  input  logic                  flush_IF_ID_i,
  input  logic                  pc_src_i,
  input  logic [ADDR_WIDTH-1:0] pc_target_i,
  input  logic                  stop_i,
  output logic [ADDR_WIDTH-1:0] PCD_o,
  output logic [DATA_WIDTH-1:0] instrD_o,
  output logic                  halted_o,
  output logic [CNT_WIDTH-1:0]  fetch_cnt_o
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pcf_q, pcf_d;
  logic [ADDR_WIDTH-1:0] pcd_q, pcd_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  halted_q, halted_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]         drain_q, drain_d;

  always_comb begin
    state_d  = state_q;
    pcf_d    = pcf_q;
    pcd_d    = pcd_q;
    instr_d  = instr_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    case (state_q)
      RUN: begin
        // A taken redirect squashes whatever sits in ID, including a STOP.
        if (pc_src_i) begin
          pcf_d   = pc_target_i;
          pcd_d   = '0;
          instr_d = NOP_INSTR;
        end else if (stop_i && !stall_IF_ID_i) begin
          pcd_d   = '0;
          instr_d = NOP_INSTR;
          state_d = DRAIN;
          drain_d = '0;
        end else if (stall_IF_ID_i) begin
          pcf_d = pcf_q;
        end else if (flush_IF_ID_i) begin
          pcf_d   = pcf_q + ADDR_WIDTH'(1);
          pcd_d   = '0;
          instr_d = NOP_INSTR;
        end else begin
          pcf_d   = pcf_q + ADDR_WIDTH'(1);
          pcd_d   = pcf_q;
          instr_d = instruction_mem_rD_i;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        end
      end
      DRAIN: begin
        pcd_d   = '0;
        instr_d = NOP_INSTR;
        drain_d = drain_q + DW'(1);
        if (drain_q == DRAIN_LAST) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end
      end
      HALTED: begin
        pcd_d    = '0;
        instr_d  = NOP_INSTR;
        halted_d = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pcf_q    <= '0;
      pcd_q    <= '0;
      instr_q  <= NOP_INSTR;
      halted_q <= 1'b0;
      cnt_q    <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      pcf_q    <= pcf_d;
      pcd_q    <= pcd_d;
      instr_q  <= instr_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
    end
  end

  assign instruction_mem_addr_o = pcf_q;
  assign PCD_o                  = pcd_q;
  assign instrD_o               = instr_q;
  assign halted_o               = halted_q;
  assign fetch_cnt_o            = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed testbench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  im_addr, im_addr4;
  logic [15:0] im_rd, im_rd4;
  logic        stall = 1'b0, flush = 1'b0, pc_src = 1'b0, stop = 1'b0;
  logic [7:0]  target = 8'h00;
  logic [7:0]  pcd, pcd4;
  logic [15:0] instr, instr4;
  logic        halted, halted4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign im_rd  = 16'h2000 + {8'h00, im_addr};
  assign im_rd4 = 16'h2000 + {8'h00, im_addr4};

  if_stage dut (
    .clk(clk), .rst(rst),
    .instruction_mem_addr_o(im_addr), .instruction_mem_rD_i(im_rd),
    .stall_IF_ID_i(stall), .flush_IF_ID_i(flush),
    .pc_src_i(pc_src), .pc_target_i(target), .stop_i(stop),
    .PCD_o(pcd), .instrD_o(instr), .halted_o(halted), .fetch_cnt_o(cnt)
  );

  if_stage #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .instruction_mem_addr_o(im_addr4), .instruction_mem_rD_i(im_rd4),
    .stall_IF_ID_i(stall), .flush_IF_ID_i(flush),
    .pc_src_i(pc_src), .pc_target_i(target), .stop_i(stop),
    .PCD_o(pcd4), .instrD_o(instr4), .halted_o(halted4), .fetch_cnt_o(cnt4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 1'b0; stop = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic jump_to(input logic [7:0] t);
    pc_src = 1'b1; target = t;
    step();
    pc_src = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (im_addr !== 8'h00) begin fails++; $display("FAIL reset_pcf: got %h want 00", im_addr); end
    tests++; if (pcd !== 8'h00) begin fails++; $display("FAIL reset_pcd: got %h want 00", pcd); end
    tests++; if (instr !== 16'hFFFF) begin fails++; $display("FAIL reset_instr: got %h want ffff", instr); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b want 0", halted); end
    tests++; if (cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
  endtask

  task automatic test_free_run();
    for (int n = 0; n < 5; n++) begin
      tests++; if (im_addr !== 8'(n)) begin fails++; $display("FAIL run_pcf: got %h want %h", im_addr, 8'(n)); end
      step();
      tests++; if (pcd !== 8'(n)) begin fails++; $display("FAIL run_pcd: got %h want %h", pcd, 8'(n)); end
      tests++; if (instr !== 16'h2000 + 16'(n)) begin fails++; $display("FAIL run_instr: got %h want %h", instr, 16'h2000 + 16'(n)); end
    end
    tests++; if (cnt !== 16'd5) begin fails++; $display("FAIL run_cnt: got %0d want 5", cnt); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests++; if (im_addr !== 8'h06) begin fails++; $display("FAIL flush_pcf: got %h want 06", im_addr); end
    tests++; if (instr !== 16'hFFFF || pcd !== 8'h00) begin fails++; $display("FAIL flush_bubble: got %h/%h want 00/ffff", pcd, instr); end
    tests++; if (cnt !== 16'd5) begin fails++; $display("FAIL flush_cnt: got %0d want 5", cnt); end
  endtask

  task automatic test_stall();
    logic [15:0] c0;
    jump_to(8'h0F);
    step();
    c0 = cnt;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++; if (im_addr !== 8'h10) begin fails++; $display("FAIL stall_pcf: got %h want 10", im_addr); end
      tests++; if (pcd !== 8'h0F || instr !== 16'h200F) begin fails++; $display("FAIL stall_ifid: got %h/%h want 0f/200f", pcd, instr); end
      tests++; if (cnt !== c0) begin fails++; $display("FAIL stall_cnt: got %0d want %0d", cnt, c0); end
    end
    stall = 1'b0;
    step();
    tests++; if (im_addr !== 8'h11 || pcd !== 8'h10 || instr !== 16'h2010) begin fails++; $display("FAIL stall_resume: got %h/%h/%h want 11/10/2010", im_addr, pcd, instr); end
    tests++; if (cnt !== c0 + 16'd1) begin fails++; $display("FAIL stall_resume_cnt: got %0d want %0d", cnt, c0 + 16'd1); end
  endtask

  task automatic test_redirect_priority();
    jump_to(8'h1F);
    step();
    pc_src = 1'b1; target = 8'h05; stall = 1'b1; stop = 1'b1;
    step();
    pc_src = 1'b0; stall = 1'b0; stop = 1'b0;
    tests++; if (im_addr !== 8'h05) begin fails++; $display("FAIL redir_pcf: got %h want 05", im_addr); end
    tests++; if (instr !== 16'hFFFF || pcd !== 8'h00) begin fails++; $display("FAIL redir_bubble: got %h/%h want 00/ffff", pcd, instr); end
    step();
    tests++; if (im_addr !== 8'h06 || pcd !== 8'h05 || instr !== 16'h2005) begin fails++; $display("FAIL redir_run: got %h/%h/%h want 06/05/2005", im_addr, pcd, instr); end
  endtask

  task automatic test_wrap();
    jump_to(8'hFE);
    step();
    tests++; if (im_addr !== 8'hFF) begin fails++; $display("FAIL wrap_pre: got %h want ff", im_addr); end
    step();
    tests++; if (im_addr !== 8'h00) begin fails++; $display("FAIL wrap_pcf: got %h want 00", im_addr); end
    tests++; if (pcd !== 8'hFF || instr !== 16'h20FF) begin fails++; $display("FAIL wrap_ifid: got %h/%h want ff/20ff", pcd, instr); end
  endtask

  task automatic test_stop();
    logic [15:0] c0;
    jump_to(8'h08);
    step();
    c0 = cnt;
    stall = 1'b1; stop = 1'b1;
    step();
    tests++; if (im_addr !== 8'h09 || pcd !== 8'h08 || instr !== 16'h2008) begin fails++; $display("FAIL stop_stalled: got %h/%h/%h want 09/08/2008", im_addr, pcd, instr); end
    stall = 1'b0;
    step();
    stop = 1'b0;
    tests++; if (im_addr !== 8'h09 || instr !== 16'hFFFF) begin fails++; $display("FAIL stop_enter: got %h/%h want 09/ffff", im_addr, instr); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL stop_h0: got %b want 0", halted); end
    pc_src = 1'b1; target = 8'h33;
    step();
    tests++; if (im_addr !== 8'h09 || halted !== 1'b0) begin fails++; $display("FAIL stop_h1: got %h/%b want 09/0", im_addr, halted); end
    pc_src = 1'b0; flush = 1'b1; stall = 1'b1;
    step();
    tests++; if (im_addr !== 8'h09 || halted !== 1'b0) begin fails++; $display("FAIL stop_h2: got %h/%b want 09/0", im_addr, halted); end
    flush = 1'b0; stall = 1'b0; pc_src = 1'b1;
    step();
    pc_src = 1'b0;
    tests++; if (halted !== 1'b1 || im_addr !== 8'h09) begin fails++; $display("FAIL stop_h3: got %b/%h want 1/09", halted, im_addr); end
    step(); step();
    tests++; if (halted !== 1'b1 || im_addr !== 8'h09 || instr !== 16'hFFFF) begin fails++; $display("FAIL stop_sticky: got %b/%h/%h want 1/09/ffff", halted, im_addr, instr); end
    tests++; if (cnt !== c0) begin fails++; $display("FAIL stop_cnt: got %0d want %0d", cnt, c0); end
    do_reset();
    tests++; if (im_addr !== 8'h00 || halted !== 1'b0 || cnt !== 16'd0) begin fails++; $display("FAIL stop_reset: got %h/%b/%0d want 00/0/0", im_addr, halted, cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) begin
        tests++; if (cnt4 !== 4'hE) begin fails++; $display("FAIL sat_14: got %h want e", cnt4); end
      end
      if (i == 15) begin
        tests++; if (cnt4 !== 4'hF) begin fails++; $display("FAIL sat_15: got %h want f", cnt4); end
      end
    end
    tests++; if (cnt4 !== 4'hF) begin fails++; $display("FAIL sat_20: got %h want f", cnt4); end
    tests++; if (cnt !== 16'd20) begin fails++; $display("FAIL sat_wide: got %0d want 20", cnt); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_flush();
    test_stall();
    test_redirect_priority();
    test_wrap();
    test_stop();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined processor.
- Holds the PC and drives the instruction-memory address (IM read is combinational).
- Owns the IF/ID pipeline register and feeds the ID stage's PCD_i and instruction_mem_rD_i inputs.
- Handles EX-resolved redirects (branch/jump), hazard-unit stall/flush, and a STOP drain/halt sequence. Also keeps a fetch counter.

Parameters:
- DATA_WIDTH, 16, instruction width.
- ADDR_WIDTH, 8, PC / IM address width.
- NOP_INSTR, 16'hFFFF, bubble word: opcode 4'b1111 (NOP), rs/rt/rd = 15.
- DRAIN_CYCLES, 3, cycles after STOP decode before halted_o (EX, MEM, WB drain).
- CNT_WIDTH, 16, fetch counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- instruction_mem_addr_o  out  ADDR_WIDTH  IM read address, equals PCF.
- instruction_mem_rD_i  in  DATA_WIDTH  IM read data for instruction_mem_addr_o, same cycle.
- stall_IF_ID_i  in  1  hazard unit: hold PC and IF/ID.
- flush_IF_ID_i  in  1  hazard unit: load bubble into IF/ID.
- pc_src_i  in  1  EX-stage redirect taken (JMPZ taken or JUMP).
- pc_target_i  in  ADDR_WIDTH  redirect target.
- stop_i  in  1  ID-stage STOP decode (combinational from ID).
- PCD_o  out  ADDR_WIDTH  address of the instruction in IF/ID.
- instrD_o  out  DATA_WIDTH  instruction in IF/ID.
- halted_o  out  1  pipeline drained after STOP; sticky.
- fetch_cnt_o  out  CNT_WIDTH  number of real (non-bubble) instructions loaded into IF/ID.

Behaviour:
- Reset (sync, on rising edge with rst=1):
  - PCF=0, PCD_o=0, instrD_o=NOP_INSTR, halted_o=0, fetch_cnt_o=0.
  - State=RUN, drain counter=0.
  - rst overrides every other input. Reset mid-drain or while HALTED returns to RUN at PC 0.
- Instruction address: instruction_mem_addr_o = PCF, combinational. One-cycle fetch latency into IF/ID.
- FSM states: RUN, DRAIN, HALTED.
- RUN, per cycle, priority highest first:
  1. pc_src_i: PCF<=pc_target_i; IF/ID<=bubble (PCD_o<=0, instrD_o<=NOP_INSTR). Overrides stall_IF_ID_i, flush_IF_ID_i and stop_i; the STOP in ID is on the wrong path and is ignored.
  2. stop_i (and no stall_IF_ID_i): PCF holds; IF/ID<=bubble; go to DRAIN; drain counter<=0.
  3. stall_IF_ID_i: PCF and IF/ID hold. stop_i is re-evaluated on the cycle the stall releases.
  4. flush_IF_ID_i: PCF<=PCF+1; IF/ID<=bubble.
  5. Otherwise: PCF<=PCF+1; PCD_o<=PCF; instrD_o<=instruction_mem_rD_i.
- PC arithmetic: modulo 2^ADDR_WIDTH; 8'hFF+1 wraps to 8'h00 with no flag.
- DRAIN:
  - PCF frozen; IF/ID forced to bubble every cycle.
  - pc_src_i, stall_IF_ID_i, flush_IF_ID_i and stop_i are ignored.
  - Drain counter increments each cycle. When counter==DRAIN_CYCLES-1, go to HALTED and assert halted_o next edge.
  - halted_o therefore rises DRAIN_CYCLES cycles after the edge that entered DRAIN.
- HALTED: everything frozen, IF/ID bubble, halted_o=1 until rst.
- fetch_cnt_o:
  - Increments by 1 only on case 5 (real instruction loaded).
  - Saturates at all-ones; never wraps.
  - Does not count bubbles, holds or redirects.
- Bubble encoding: NOP_INSTR decodes as NOP in ID, giving a zero control vector and no register write.

Test Plan:
- Reset then free-run with IM[n]=16'h2000+n, all controls 0 -> PCF 0,1,2,...; one cycle after each address, PCD_o=n and instrD_o=16'h2000+n; fetch_cnt_o=5 after 5 fetches.
- PCF=8'h10, stall_IF_ID_i=1 for 2 cycles -> PCF, PCD_o and instrD_o unchanged for 2 cycles, fetch_cnt_o unchanged; fetching resumes at 8'h10.
- PCF=8'h20, pc_src_i=1, pc_target_i=8'h05, stall_IF_ID_i=1, stop_i=1 same cycle -> next PCF=8'h05, instrD_o=16'hFFFF, state stays RUN.
- PCF=8'hFF, no stall -> next PCF=8'h00; IF/ID holds PCD_o=8'hFF.
- STOP decoded (stop_i=1) at PCF=8'h09 -> PCF frozen at 8'h09, instrD_o=16'hFFFF; halted_o=1 exactly 3 edges later; pc_src_i pulses during DRAIN are ignored; rst afterward returns PCF=0, halted_o=0.
- Preload fetch_cnt_o near saturation (CNT_WIDTH=4), 20 fetches -> fetch_cnt_o sticks at 4'hF.
